mtm_alu_serializer: RTL and testbench

Output serializer of the 32-bit ALU: it takes a completed result word C and its control byte CTL and sends them MSB-first on the single-wire serial output `sout`, using the same 11-bit frame format the ALU's input deserializer decodes. It sits between the ALU core's registered outputs and the chip pin. A normal result goes out as four DATA frames followed by one CTL frame. An error response goes out as a single CTL frame.

---
 rtl/mtm_alu_pkg.sv | 39 +++
 rtl/mtm_alu_frame_tx.sv | 94 +++++++++
 rtl/mtm_alu_serializer.sv | 75 +++++++
 tb/tb_mtm_alu_serializer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared protocol constants for the ALU serial frame format.
// Used by the input deserializer, the core and the output serializer.
package mtm_alu_pkg;

  localparam int          FRAME_BITS   = 11;
  localparam logic        PKT_DATA     = 1'b0;
  localparam logic        PKT_CTL      = 1'b1;
  localparam int          N_DATA_BYTES = 4;

  localparam logic [7:0]  CTL_IDLE     = 8'hFF;
  localparam logic [7:0]  ERR_CTL_A    = 8'hA5;
  localparam logic [7:0]  ERR_CTL_B    = 8'hC9;
  localparam logic [7:0]  ERR_CTL_C    = 8'h93;

  // Frame FSM states; each state names the bit currently on the line.
  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_START = 3'd1;
  localparam logic [2:0]  ST_TYPE  = 3'd2;
  localparam logic [2:0]  ST_DATA  = 3'd3;
  localparam logic [2:0]  ST_STOP  = 3'd4;

  // Byte index 0..3 selects C MSB-first; index 4 is the CTL frame.
  localparam logic [2:0]  CTL_BYTE_IDX = 3'd4;

  function automatic logic [7:0] select_byte(input logic [31:0] word,
                                             input logic [7:0]  ctl,
                                             input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = word[31:24];
      3'd1:    b = word[23:16];
      3'd2:    b = word[15:8];
      3'd3:    b = word[7:0];
      default: b = ctl;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mtm_alu_frame_tx.sv
// One-frame shifter: start, type, 8 payload bits MSB-first, stop.
// A start request during the stop bit chains the next frame with no gap.
module mtm_alu_frame_tx
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       type_i,
  input  logic [7:0] byte_i,
  output logic       sout_o,
  output logic       busy_o,
  output logic       idle_o,
  output logic       done_o
);

  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_q, byte_d;
  logic       type_q, type_d;
  logic       sout_q, sout_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    byte_d    = byte_q;
    type_d    = type_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_START;
          byte_d  = byte_i;
          type_d  = type_i;
        end
      end
      ST_START: state_d = ST_TYPE;
      ST_TYPE: begin
        state_d   = ST_DATA;
        bit_cnt_d = 3'd7;
      end
      ST_DATA: begin
        if (bit_cnt_q == 3'd0) state_d = ST_STOP;
        else                   bit_cnt_d = bit_cnt_q - 3'd1;
      end
      ST_STOP: begin
        if (start_i) begin
          state_d = ST_START;
          byte_d  = byte_i;
          type_d  = type_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line is registered, so the value is derived from the next state.
  always_comb begin
    sout_d = 1'b1;
    case (state_d)
      ST_START: sout_d = 1'b0;
      ST_TYPE:  sout_d = type_d;
      ST_DATA:  sout_d = byte_d[bit_cnt_d];
      default:  sout_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      byte_q    <= 8'h00;
      type_q    <= PKT_DATA;
      sout_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      byte_q    <= byte_d;
      type_q    <= type_d;
      sout_q    <= sout_d;
      busy_q    <= busy_d;
    end
  end

  assign sout_o = sout_q;
  assign busy_o = busy_q;
  assign idle_o = (state_q == ST_IDLE);
  assign done_o = (state_q == ST_STOP);

endmodule

// File: rtl/mtm_alu_serializer.sv
// ALU result serializer: word sequencer that feeds four DATA frames and a
// CTL frame (or just the CTL frame for an error) to the frame shifter.
module mtm_alu_serializer
  import mtm_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] C,
  input  logic [7:0]  CTL,
  output logic        sout,
  output logic        busy
);

  logic [31:0] c_q, c_d;
  logic [7:0]  ctl_q, ctl_d;
  logic [2:0]  byte_idx_q, byte_idx_d;

  logic        tx_idle;
  logic        tx_done;
  logic        accept;
  logic        next_frame;
  logic        frame_start;
  logic [2:0]  sel_idx;
  logic [7:0]  sel_byte;
  logic        sel_type;

  assign in_ready   = tx_idle;
  assign accept     = in_valid && in_ready;
  assign next_frame = tx_done && (byte_idx_q != CTL_BYTE_IDX);
  assign frame_start = accept || next_frame;

  // On the accept edge the first frame is taken straight from the inputs,
  // since the latches only update at that same edge.
  always_comb begin
    if (accept) begin
      sel_idx  = CTL[7] ? CTL_BYTE_IDX : 3'd0;
      sel_byte = select_byte(C, CTL, sel_idx);
    end else begin
      sel_idx  = byte_idx_q + 3'd1;
      sel_byte = select_byte(c_q, ctl_q, sel_idx);
    end
    sel_type = (sel_idx == CTL_BYTE_IDX) ? PKT_CTL : PKT_DATA;

    c_d        = accept ? C : c_q;
    ctl_d      = accept ? CTL : ctl_q;
    byte_idx_d = frame_start ? sel_idx : byte_idx_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q        <= 32'h0;
      ctl_q      <= 8'h00;
      byte_idx_q <= 3'd0;
    end else begin
      c_q        <= c_d;
      ctl_q      <= ctl_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  mtm_alu_frame_tx u_frame_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (frame_start),
    .type_i  (sel_type),
    .byte_i  (sel_byte),
    .sout_o  (sout),
    .busy_o  (busy),
    .idle_o  (tx_idle),
    .done_o  (tx_done)
  );

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Directed bench for mtm_alu_serializer: idle, normal, error, back-to-back,
// input-stability and mid-response reset scenarios.
module tb_mtm_alu_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] C = 32'h0;
  logic [7:0]  CTL = 8'h00;
  logic        sout;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mtm_alu_serializer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .C        (C),
    .CTL      (CTL),
    .sout     (sout),
    .busy     (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " sout"}, sout, 1'b1);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " in_ready"}, in_ready, 1'b1);
  endtask

  // Present a word and take the accept edge.
  task automatic offer(input logic [31:0] c, input logic [7:0] ctl);
    C = c;
    CTL = ctl;
    in_valid = 1'b1;
    chk("offer in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  // Check the expected bit stream starting with the current cycle.
  // nbits < 0 checks the whole response; scramble randomises C/CTL each cycle.
  task automatic expect_response(input logic [31:0] c, input logic [7:0] ctl,
                                 input bit scramble, input int nbits);
    logic [7:0] fr_byte;
    logic       fr_type;
    bit         bits[$];
    int         first;
    int         limit;
    first = ctl[7] ? 4 : 0;
    for (int f = first; f < 5; f++) begin
      case (f)
        0: fr_byte = c[31:24];
        1: fr_byte = c[23:16];
        2: fr_byte = c[15:8];
        3: fr_byte = c[7:0];
        default: fr_byte = ctl;
      endcase
      fr_type = (f == 4);
      bits.push_back(1'b0);
      bits.push_back(fr_type);
      for (int b = 7; b >= 0; b--) bits.push_back(fr_byte[b]);
      bits.push_back(1'b1);
    end
    limit = (nbits < 0) ? bits.size() : nbits;
    $display("response C=%h CTL=%h: checking %0d of %0d bits", c, ctl, limit, bits.size());
    for (int i = 0; i < limit; i++) begin
      if (scramble) begin
        C = $urandom;
        CTL = 8'($urandom);
      end
      chk($sformatf("bit%0d sout", i), sout, bits[i]);
      chk($sformatf("bit%0d busy", i), busy, 1'b1);
      chk($sformatf("bit%0d in_ready", i), in_ready, 1'b0);
      tick();
    end
  endtask

  initial begin
    // Reset and idle
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check_idle($sformatf("idle%0d", i));
      tick();
    end

    // Normal response
    offer(32'h12345678, 8'h4A);
    C = 32'hFFFF_FFFF;
    CTL = 8'h00;
    expect_response(32'h12345678, 8'h4A, 1'b0, -1);
    check_idle("after normal");
    tick();

    // Error response
    offer(32'hDEADBEEF, 8'hA5);
    expect_response(32'hDEADBEEF, 8'hA5, 1'b0, -1);
    check_idle("after error");
    tick();

    // Back-to-back with in_valid held high
    C = 32'h5555_AAAA;
    CTL = 8'h93;
    in_valid = 1'b1;
    chk("queue1 in_ready", in_ready, 1'b1);
    tick();
    C = 32'h0;
    CTL = 8'h10;
    expect_response(32'h0, 8'h93, 1'b0, -1);
    check_idle("queue gap");
    tick();
    in_valid = 1'b0;
    expect_response(32'h0, 8'h10, 1'b0, -1);
    check_idle("after queue");
    tick();

    // Inputs change every cycle during the response
    offer(32'hA1B2C3D4, 8'h21);
    expect_response(32'hA1B2C3D4, 8'h21, 1'b1, -1);
    check_idle("after scramble");
    tick();

    // Reset during bit 30 of a normal response
    offer(32'h0F1E2D3C, 8'h05);
    expect_response(32'h0F1E2D3C, 8'h05, 1'b0, 30);
    rst_n = 1'b0;
    tick();
    check_idle("post reset");
    rst_n = 1'b1;
    tick();
    check_idle("post reset release");
    tick();
    offer(32'hCAFEF00D, 8'h3C);
    expect_response(32'hCAFEF00D, 8'h3C, 1'b0, -1);
    check_idle("after recovery");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
